// File: rtl/mag_pow_gen.sv
// mag_pow_gen: magnitude-power basis generator for the DPD datapath.
// Computes M = floor(sqrt(I^2 + Q^2)) with a W-stage restoring square root,
// then builds |x|^0 .. |x|^(N_POW-1) in unsigned Q1.(W-1) via a rounding,
// saturating multiplier chain. All powers leave on one word with out_valid.
//
// Ports:
//   clk        system clock
//   rst        synchronous active-high reset (clears valid chain and output)
//   in_valid   input sample qualifier
//   sig_in_i   signed in-phase sample, W bits
//   sig_in_q   signed quadrature sample, W bits
//   out_valid  output word qualifier
//   mag_o      packed powers, slice k at [k*W +: W] = |x|^k
//
// Latency: 1 (square) + W (sqrt) + max(N_POW-2,0) (chain) + 1 (output reg).

module mag_pow_gen #(
   parameter int W     = 20,
   parameter int N_POW = 5,
   parameter int ROUND = 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   input  logic signed [W-1:0] sig_in_i,
   input  logic signed [W-1:0] sig_in_q,
   output logic                out_valid,
   output logic [N_POW*W-1:0]  mag_o
);

   localparam int W2  = 2 * W;
   localparam int RW  = W + 4;                       // sqrt partial remainder width
   localparam int NC  = (N_POW > 2) ? N_POW - 2 : 0; // multiplier chain stages
   localparam int NCS = (NC > 0) ? NC : 1;           // storage size, never zero
   localparam logic [W-1:0] P0 = {1'b0, {(W-1){1'b1}}};

   // One restoring sqrt step: bring in the next two radicand bits, try to
   // subtract (4*root + 1); success appends a 1 to the root, failure a 0.
   function automatic logic [RW+W-1:0] sqrt_step(input logic [RW-1:0] rem,
                                                 input logic [W-1:0]  root,
                                                 input logic [1:0]    bits);
      logic [RW-1:0] cur;
      logic [RW-1:0] trial;
      cur   = {rem[RW-3:0], bits};
      trial = {2'b00, root, 2'b01};
      if (cur >= trial) begin
         return {cur - trial, root[W-2:0], 1'b1};
      end else begin
         return {cur, root[W-2:0], 1'b0};
      end
   endfunction

   // Rescale a 2W-bit product back to Q1.(W-1); the rounding carry takes
   // part in the saturation test, so 2^W-1 + carry clamps rather than wraps.
   function automatic logic [W-1:0] rs(input logic [W2-1:0] x);
      logic [W+1:0] y;
      y = {1'b0, x[W2-1:W-1]};
      if (ROUND != 0) begin
         y = y + {{(W+1){1'b0}}, x[W-2]};
      end
      if (y[W+1:W] != 2'b00) begin
         return '1;
      end else begin
         return y[W-1:0];
      end
   endfunction

   // S0: exact sum of squares
   logic signed [W2-1:0] i_ext, q_ext, ii_sq, qq_sq;
   logic [W2-1:0]        r_d, r_q;
   logic                 s0_vld_d, s0_vld_q;

   always_comb begin
      i_ext    = W2'(sig_in_i);
      q_ext    = W2'(sig_in_q);
      ii_sq    = i_ext * i_ext;
      qq_sq    = q_ext * q_ext;
      r_d      = $unsigned(ii_sq) + $unsigned(qq_sq);
      s0_vld_d = in_valid;
   end

   // S1..SW: square root pipeline; radicand shifts left two bits per stage
   logic [RW-1:0]    rem_d  [W];
   logic [RW-1:0]    rem_q  [W];
   logic [W-1:0]     root_d [W];
   logic [W-1:0]     root_q [W];
   logic [W2-1:0]    rad_d  [W];
   logic [W2-1:0]    rad_q  [W];
   logic             sv_d   [W];
   logic             sv_q   [W];
   logic [RW+W-1:0]  step;

   always_comb begin
      step       = sqrt_step('0, '0, r_q[W2-1 -: 2]);
      rem_d[0]   = step[RW+W-1 -: RW];
      root_d[0]  = step[W-1:0];
      rad_d[0]   = r_q << 2;
      sv_d[0]    = s0_vld_q;
      for (int unsigned s = 1; s < W; s++) begin
         step      = sqrt_step(rem_q[s-1], root_q[s-1], rad_q[s-1][W2-1 -: 2]);
         rem_d[s]  = step[RW+W-1 -: RW];
         root_d[s] = step[W-1:0];
         rad_d[s]  = rad_q[s-1] << 2;
         sv_d[s]   = sv_q[s-1];
      end
   end

   // Power chain. pin[c] is the power vector entering chain stage c (pin[NC]
   // feeds the output register); each stage passes lower powers through and
   // adds the next one, so all slices stay aligned to one sample.
   logic [W-1:0] pin  [NC+1][N_POW];
   logic         vin  [NC+1];
   logic [W-1:0] pw_d [NCS][N_POW];
   logic [W-1:0] pw_q [NCS][N_POW];
   logic         cv_d [NCS];
   logic         cv_q [NCS];

   always_comb begin
      for (int unsigned k = 0; k < N_POW; k++) begin
         pin[0][k] = '0;
      end
      pin[0][1] = root_q[W-1];
      vin[0]    = sv_q[W-1];
      for (int unsigned c = 0; c < NC; c++) begin
         pin[c+1] = pw_q[c];
         vin[c+1] = cv_q[c];
      end
      for (int unsigned c = 0; c < NCS; c++) begin
         for (int unsigned k = 0; k < N_POW; k++) begin
            pw_d[c][k] = '0;
         end
         cv_d[c] = 1'b0;
      end
      for (int unsigned c = 0; c < NC; c++) begin
         pw_d[c]      = pin[c];
         pw_d[c][c+2] = rs({{W{1'b0}}, pin[c][c+1]} * {{W{1'b0}}, pin[c][1]});
         cv_d[c]      = vin[c];
      end
   end

   // Output register: loads only on a valid word, otherwise holds
   logic               out_valid_d, out_valid_q;
   logic [N_POW*W-1:0] mag_d, mag_q;

   always_comb begin
      out_valid_d = 1'b0;
      mag_d       = mag_q;
      if (vin[NC]) begin
         out_valid_d = 1'b1;
         mag_d[0 +: W] = P0;
         for (int unsigned k = 1; k < N_POW; k++) begin
            mag_d[k*W +: W] = pin[NC][k];
         end
      end
   end

   // Valid chain and output register: reset
   always_ff @(posedge clk) begin
      if (rst) begin
         s0_vld_q <= 1'b0;
         for (int unsigned s = 0; s < W; s++) begin
            sv_q[s] <= 1'b0;
         end
         for (int unsigned c = 0; c < NCS; c++) begin
            cv_q[c] <= 1'b0;
         end
         out_valid_q <= 1'b0;
         mag_q       <= '0;
      end else begin
         s0_vld_q    <= s0_vld_d;
         sv_q        <= sv_d;
         cv_q        <= cv_d;
         out_valid_q <= out_valid_d;
         mag_q       <= mag_d;
      end
   end

   // Datapath: no reset needed, qualified by the valid chain
   always_ff @(posedge clk) begin
      r_q    <= r_d;
      rem_q  <= rem_d;
      root_q <= root_d;
      rad_q  <= rad_d;
      pw_q   <= pw_d;
   end

   assign out_valid = out_valid_q;
   assign mag_o     = mag_q;

endmodule

// File: tb/tb_mag_pow_gen.sv
// tb_mag_pow_gen: directed bench for mag_pow_gen at W=20, N_POW=5, driving a
// ROUND=1 and a ROUND=0 instance with the same stimulus.
module tb_mag_pow_gen;

   localparam int W   = 20;
   localparam int NP  = 5;
   localparam int LAT = 25;

   logic                clk = 1'b0;
   logic                rst;
   logic                in_valid;
   logic signed [W-1:0] si, sq;
   logic                ov_r, ov_t;
   logic [NP*W-1:0]     mag_r, mag_t;
   logic [NP*W-1:0]     last_r, last_t;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mag_pow_gen #(.W(W), .N_POW(NP), .ROUND(1)) dut_r (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .sig_in_i(si), .sig_in_q(sq),
      .out_valid(ov_r), .mag_o(mag_r)
   );

   mag_pow_gen #(.W(W), .N_POW(NP), .ROUND(0)) dut_t (
      .clk(clk), .rst(rst), .in_valid(in_valid),
      .sig_in_i(si), .sig_in_q(sq),
      .out_valid(ov_t), .mag_o(mag_t)
   );

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [NP*W-1:0] pk(input longint p0, input longint p1, input longint p2,
                                          input longint p3, input longint p4);
      logic [W-1:0] a0, a1, a2, a3, a4;
      a0 = W'(p0); a1 = W'(p1); a2 = W'(p2); a3 = W'(p3); a4 = W'(p4);
      return {a4, a3, a2, a1, a0};
   endfunction

   // Bit-exact reference: square root by building the root from the top bit
   // down and testing its square; powers rescaled in 64-bit arithmetic.
   function automatic logic [NP*W-1:0] model(input logic signed [W-1:0] i, input logic signed [W-1:0] q,
                                             input bit rnd);
      longint r, m, t, x, y;
      longint p [NP];
      r = longint'(i) * longint'(i) + longint'(q) * longint'(q);
      m = 0;
      for (int b = W - 1; b >= 0; b--) begin
         t = m | (64'sd1 <<< b);
         if (t * t <= r) m = t;
      end
      p[0] = (64'sd1 <<< (W - 1)) - 1;
      p[1] = m;
      for (int k = 2; k < NP; k++) begin
         x = p[k-1] * m;
         y = x >>> (W - 1);
         if (rnd) y = y + ((x >>> (W - 2)) & 1);
         if (y >= (64'sd1 <<< W)) y = (64'sd1 <<< W) - 1;
         p[k] = y;
      end
      return pk(p[0], p[1], p[2], p[3], p[4]);
   endfunction

   task automatic drive(input logic v, input logic signed [W-1:0] i, input logic signed [W-1:0] q);
      in_valid = v;
      si       = i;
      sq       = q;
   endtask

   // One isolated sample: no output for LAT-1 cycles, one word at LAT, then hold.
   task automatic run_one(input string tag, input logic signed [W-1:0] i, input logic signed [W-1:0] q,
                          input logic [NP*W-1:0] er, input logic [NP*W-1:0] et);
      drive(1'b1, i, q);
      tick();
      drive(1'b0, '0, '0);
      for (int c = 1; c < LAT; c++) begin
         if (c == LAT - 1) begin
            chk({tag, " early ov_r"}, 128'(ov_r), 128'(1'b0));
            chk({tag, " early ov_t"}, 128'(ov_t), 128'(1'b0));
         end
         tick();
      end
      chk({tag, " ov_r"}, 128'(ov_r), 128'(1'b1));
      chk({tag, " ov_t"}, 128'(ov_t), 128'(1'b1));
      chk({tag, " mag_r"}, 128'(mag_r), 128'(er));
      chk({tag, " mag_t"}, 128'(mag_t), 128'(et));
      tick();
      chk({tag, " ov_r drop"}, 128'(ov_r), 128'(1'b0));
      chk({tag, " mag_r hold"}, 128'(mag_r), 128'(er));
      last_r = er;
      last_t = et;
   endtask

   bit                  pat [7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
   bit                  ev  [100];
   logic [NP*W-1:0]     emr [100];
   logic [NP*W-1:0]     emt [100];

   initial begin
      logic signed [W-1:0] ri, rq;
      logic [NP*W-1:0]     sat;
      int                  idx;

      // Reset, with in_valid high during reset (must be discarded)
      rst = 1'b1;
      drive(1'b1, 20'sd1000, 20'sd1000);
      tick();
      tick();
      chk("reset ov_r", 128'(ov_r), 128'(1'b0));
      chk("reset mag_r", 128'(mag_r), 128'(0));
      chk("reset ov_t", 128'(ov_t), 128'(1'b0));
      chk("reset mag_t", 128'(mag_t), 128'(0));
      rst = 1'b0;
      drive(1'b0, '0, '0);
      tick();

      // Zero input: exact latency, P0 constant, other powers zero
      run_one("zero", 20'sd0, 20'sd0, pk(524287, 0, 0, 0, 0), pk(524287, 0, 0, 0, 0));

      // 3-4-5 triangle in Q1.19, rounding vs truncation differ only in P4
      run_one("345", 20'sd300000, 20'sd400000,
              pk(524287, 500000, 476837, 454747, 433681),
              pk(524287, 500000, 476837, 454747, 433680));

      // Most negative input on both rails: largest magnitude, powers saturate
      sat = pk(524287, 741455, 1048575, 1048575, 1048575);
      run_one("negmax", -20'sd524288, -20'sd524288, sat, sat);

      // Just under unity on one rail
      run_one("unity", 20'sd524287, 20'sd0,
              pk(524287, 524287, 524286, 524285, 524284),
              pk(524287, 524287, 524286, 524285, 524284));

      // Small magnitude, negative operands
      run_one("small", -20'sd3, -20'sd4, pk(524287, 5, 0, 0, 0), pk(524287, 5, 0, 0, 0));

      // Random stream with gapped valid pattern
      for (int m = 0; m < 100 + LAT; m++) begin
         if (m < 100) begin
            ri     = W'($urandom);
            rq     = W'($urandom);
            ev[m]  = pat[m % 7];
            emr[m] = model(ri, rq, 1'b1);
            emt[m] = model(ri, rq, 1'b0);
            drive(ev[m], ri, rq);
         end else begin
            drive(1'b0, '0, '0);
         end
         tick();
         idx = m - (LAT - 1);
         if (idx >= 0 && idx < 100) begin
            chk($sformatf("stream ov_r[%0d]", idx), 128'(ov_r), 128'(ev[idx]));
            chk($sformatf("stream ov_t[%0d]", idx), 128'(ov_t), 128'(ev[idx]));
            if (ev[idx]) begin
               last_r = emr[idx];
               last_t = emt[idx];
            end
            chk($sformatf("stream mag_r[%0d]", idx), 128'(mag_r), 128'(last_r));
            chk($sformatf("stream mag_t[%0d]", idx), 128'(mag_t), 128'(last_t));
         end else if (idx < 0) begin
            chk($sformatf("stream idle ov_r[%0d]", m), 128'(ov_r), 128'(1'b0));
         end
      end

      // Fill the pipeline, then a one-cycle reset mid-stream
      for (int m = 0; m < 30; m++) begin
         drive(1'b1, W'($urandom), W'($urandom));
         tick();
      end
      rst = 1'b1;
      drive(1'b1, 20'sd1234, 20'sd5678);
      tick();
      chk("midrst ov_r", 128'(ov_r), 128'(1'b0));
      chk("midrst mag_r", 128'(mag_r), 128'(0));
      chk("midrst ov_t", 128'(ov_t), 128'(1'b0));
      chk("midrst mag_t", 128'(mag_t), 128'(0));
      rst = 1'b0;
      drive(1'b0, '0, '0);
      for (int c = 0; c < 3; c++) begin
         tick();
         chk($sformatf("postrst idle ov_r[%0d]", c), 128'(ov_r), 128'(1'b0));
      end
      drive(1'b1, 20'sd300000, 20'sd400000);
      tick();
      drive(1'b0, '0, '0);
      for (int c = 1; c < LAT; c++) begin
         chk($sformatf("postrst flush ov_r[%0d]", c), 128'(ov_r), 128'(1'b0));
         chk($sformatf("postrst flush mag_r[%0d]", c), 128'(mag_r), 128'(0));
         tick();
      end
      chk("postrst ov_r", 128'(ov_r), 128'(1'b1));
      chk("postrst mag_r", 128'(mag_r), 128'(pk(524287, 500000, 476837, 454747, 433681)));
      chk("postrst ov_t", 128'(ov_t), 128'(1'b1));
      chk("postrst mag_t", 128'(mag_t), 128'(pk(524287, 500000, 476837, 454747, 433680)));
      tick();
      chk("postrst ov_r drop", 128'(ov_r), 128'(1'b0));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
